custom_axi_lite_master: RTL and testbench
=========================================

# custom_axi_lite_master

AXI4-Lite manager (initiator) that turns single request/response commands into AXI-Lite read or write transactions toward a register-mapped subordinate such as the custom AXI IP register block. It sits between a local controller (debug bridge, sequencer, CPU-side shim) and the AXI-Lite fabric. It keeps exactly one transaction outstanding and recovers from hung subordinates with a timeout.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte strobe width is DATA_W/8
- TIMEOUT_CYCLES, 256, maximum wait cycles per transaction; 0 disables the timeout

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when both are high
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  target byte address
- req_wdata  in  DATA_W  write data
- req_wstrb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when both are high
- rsp_write  out  1  echoes req_write of the completed command
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- rsp_resp  out  2  AXI response code (OKAY=00, SLVERR=10)
- rsp_timeout  out  1  transaction aborted by timeout
- m_axi_awaddr / awvalid / awready  out/out/in  ADDR_W/1/1  write address channel
- m_axi_wdata / wstrb / wvalid / wready  out/out/out/in  DATA_W/DATA_W/8/1/1  write data channel
- m_axi_bresp / bvalid / bready  in/in/out  2/1/1  write response channel
- m_axi_araddr / arvalid / arready  out/out/in  ADDR_W/1/1  read address channel
- m_axi_rdata / rresp / rvalid / rready  in/in/in/out  DATA_W/2/1/1  read data channel

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: req_ready = 1 (forced 0 while rst is high). On req_valid && req_ready, latch addr/wdata/wstrb/write and go to WR_REQ or RD_REQ.
- WR_REQ: awvalid and wvalid both rise on entry. Each is held with stable payload until its own handshake, independently; awready and wready may arrive in either order or in the same cycle. Once both channels have completed, go to WR_RESP.
- WR_RESP: bready = 1. On bvalid, capture bresp, set rsp_rdata = 0, and go to RSP.
- RD_REQ: arvalid held with stable araddr until arready, then go to RD_RESP.
- RD_RESP: rready = 1. On rvalid, capture rdata and rresp, then go to RSP.
- RSP: rsp_valid = 1 with all rsp_* fields stable until rsp_ready, then go to IDLE. A new command is accepted no earlier than the cycle after the return to IDLE.
- Timeout: a counter clears on leaving IDLE and increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP. When it reaches TIMEOUT_CYCLES - 1 without completion:
  - drop all AXI valid and ready outputs;
  - go to RSP with rsp_resp = 10, rsp_timeout = 1, rsp_rdata = 0.
- The counter width is $clog2(TIMEOUT_CYCLES+1). Dropping a valid on timeout is recovery-only behaviour. Late responses arriving after a timeout are not filtered.
- Subordinate EXOKAY/DECERR codes pass through unmodified; rsp_timeout = 0 in those cases.

## Timing
- Reset: state IDLE; all AXI valid/ready outputs 0; rsp_valid 0; rsp_write 0; rsp_rdata 0; rsp_resp 00; rsp_timeout 0; AXI address/data outputs 0.
- All AXI outputs are registered or decoded from state only. There is no combinational path from any AXI input to any AXI output.
- With a zero-wait subordinate:
  - cycle 0: command accepted;
  - cycle 1: aw/w/ar valid asserted;
  - cycle 2: bready/rready asserted;
  - cycle 3: rsp_valid.
- Minimum command-to-command spacing is 4 cycles.
- rst asserted mid-transaction returns the block to reset values on the next edge. No response is emitted for the aborted command.

## Structure
- Package custom_axi_lite_pkg holds:
  - resp_e: OKAY, EXOKAY, SLVERR, DECERR;
  - mst_state_e;
  - a default TIMEOUT_CYCLES constant.
- A single module; no sub-module is required. The timeout counter stays inline.

## Test plan
- Write addr 0x4, data 0xDEADBEEF, strb 0xF, zero-wait subordinate -> awaddr = 0x4 and wdata = 0xDEADBEEF in cycle 1; rsp_valid in cycle 3 with resp 00, rsp_write 1, rdata 0.
- Write where wready arrives 3 cycles before awready -> wvalid drops after its handshake; awvalid holds until its own; exactly one B handshake; rsp resp 00.
- Read addr 0x8 with the subordinate returning 0x12345678 after 2 wait cycles -> rsp_rdata 0x12345678, resp 00, rsp_write 0.
- Read with TIMEOUT_CYCLES = 16 and arready stuck at 0 -> arvalid drops after 16 cycles; rsp resp 10, rsp_timeout 1, rdata 0.
- rsp_ready held low for 5 cycles, with req_valid held high -> rsp fields stable throughout; req_ready stays 0 until the cycle after the rsp handshake.
- rst pulsed in WR_RESP -> all outputs at reset values on the next cycle; no rsp_valid; the next write completes normally.

Source files
------------

// File: rtl/custom_axi_lite_pkg.sv
// Shared types and defaults for the custom AXI4-Lite manager.
package custom_axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } mst_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/custom_axi_lite_master.sv
// AXI4-Lite manager: one outstanding single-beat read or write per command,
// with a per-transaction timeout that aborts hung subordinates.
module custom_axi_lite_master
  import custom_axi_lite_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  output mst_state_e          dbg_state_o
);

  // Handshakes: every channel (req, rsp, AW, W, B, AR, R) transfers on a rising
  // edge where valid && ready; a raised valid keeps its payload stable until
  // that transfer, except when a timeout aborts the transaction.

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  mst_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              write_q, write_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              timeout_hit;
  logic              abort;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    write_d       = write_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    cnt_d         = cnt_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    abort         = 1'b0;
    timeout_hit   = TO_EN && (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          write_d   = req_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          cnt_d     = '0;
          state_d   = req_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        cnt_d     = cnt_q + CNT_W'(1);
        // AW and W complete independently; leave only once both have fired.
        aw_done_d = aw_done_q | m_axi_awready;
        w_done_d  = w_done_q | m_axi_wready;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
        else                       abort   = timeout_hit;
      end
      WR_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (m_axi_bvalid) begin
          state_d       = RSP;
          rsp_write_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = m_axi_bresp;
          rsp_timeout_d = 1'b0;
        end else begin
          abort = timeout_hit;
        end
      end
      RD_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (m_axi_arready) state_d = RD_RESP;
        else               abort   = timeout_hit;
      end
      RD_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (m_axi_rvalid) begin
          state_d       = RSP;
          rsp_write_d   = 1'b0;
          rsp_rdata_d   = m_axi_rdata;
          rsp_resp_d    = m_axi_rresp;
          rsp_timeout_d = 1'b0;
        end else begin
          abort = timeout_hit;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d       = RSP;
      rsp_write_d   = write_q;
      rsp_rdata_d   = '0;
      rsp_resp_d    = SLVERR;
      rsp_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      write_q       <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      cnt_q         <= '0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      write_q       <= write_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      cnt_q         <= cnt_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Every AXI output is a register or a decode of registered state.
  assign req_ready     = (state_q == IDLE) && !rst;
  assign rsp_valid     = (state_q == RSP);
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign m_axi_bready  = (state_q == WR_RESP);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = (state_q == RD_REQ);
  assign m_axi_rready  = (state_q == RD_RESP);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_custom_axi_lite_master.sv
// Directed bench for custom_axi_lite_master: configurable subordinate model,
// response scoreboard with a monitor, and cycle-level channel checks.
module tb_custom_axi_lite_master;
  import custom_axi_lite_pkg::*;

  localparam int RSP_W = 36;  // {write, timeout, resp[1:0], rdata[31:0]}

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  mst_state_e  dbg_state;

  // Scoreboard and counters
  logic [RSP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rsp_seen = 0;
  int b_count = 0;
  int cnt;

  // Subordinate model configuration and state
  int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = 32'h0;
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  logic aw_done_s, w_done_s, b_pend, r_pend;
  logic aw_fire, w_fire, ar_fire, b_fire, r_fire;
  logic [RSP_W-1:0] mon_act, mon_exp;

  custom_axi_lite_master #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .dbg_state_o(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RSP_W-1:0] pack(input logic w, input logic to,
                                            input logic [1:0] r, input logic [31:0] d);
    return {w, to, r, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input logic do_push, input logic [RSP_W-1:0] exp);
    int n = 0;
    req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = st; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL send_stall: got req_ready=0 expected 1 within 50 cycles");
    end
    if (do_push) exp_q.push_back(exp);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int target = rsp_seen + 1;
    int n = 0;
    while (rsp_seen < target && n < 100) begin
      tick();
      n++;
    end
    if (rsp_seen < target) begin
      checks++;
      errors++;
      $display("FAIL %s_rsp_wait: got no response expected one within 100 cycles", name);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; rsp_ready = 1'b1;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = '0; m_axi_rvalid = 1'b0; m_axi_rresp = '0;
    m_axi_rdata = '0;

    fork
      // Subordinate model: decides this cycle's readies/valids at posedge+2
      forever begin
        @(posedge clk);
        #2;
        if (rst) begin
          m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
          m_axi_bvalid = 0; m_axi_rvalid = 0;
          aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
          aw_done_s = 0; w_done_s = 0; b_pend = 0; r_pend = 0;
          aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
        end else begin
          if (aw_fire) aw_done_s = 1;
          if (w_fire) w_done_s = 1;
          if (b_fire) begin m_axi_bvalid = 0; b_count++; end
          if (r_fire) m_axi_rvalid = 0;
          if (ar_fire) begin r_pend = 1; r_wait = 0; end
          if (aw_done_s && w_done_s) begin
            aw_done_s = 0; w_done_s = 0; b_pend = 1; b_wait = 0;
          end
          if (b_pend) begin
            if (b_wait >= b_delay) begin
              m_axi_bvalid = 1; m_axi_bresp = b_resp_cfg; b_pend = 0;
            end else b_wait++;
          end
          if (r_pend) begin
            if (r_wait >= r_delay) begin
              m_axi_rvalid = 1; m_axi_rdata = r_data_cfg; m_axi_rresp = r_resp_cfg; r_pend = 0;
            end else r_wait++;
          end
          if (m_axi_awvalid) begin m_axi_awready = (aw_wait >= aw_delay); aw_wait++; end
          else begin m_axi_awready = 0; aw_wait = 0; end
          if (m_axi_wvalid) begin m_axi_wready = (w_wait >= w_delay); w_wait++; end
          else begin m_axi_wready = 0; w_wait = 0; end
          if (m_axi_arvalid) begin m_axi_arready = (ar_wait >= ar_delay); ar_wait++; end
          else begin m_axi_arready = 0; ar_wait = 0; end
          aw_fire = m_axi_awvalid && m_axi_awready;
          w_fire  = m_axi_wvalid && m_axi_wready;
          ar_fire = m_axi_arvalid && m_axi_arready;
          b_fire  = m_axi_bvalid && m_axi_bready;
          r_fire  = m_axi_rvalid && m_axi_rready;
        end
      end
      // Response monitor
      forever begin
        @(negedge clk);
        if (!rst && rsp_valid && rsp_ready) begin
          mon_act = {rsp_write, rsp_timeout, rsp_resp, rsp_rdata};
          rsp_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got %0h expected no response", mon_act);
          end else begin
            mon_exp = exp_q.pop_front();
            check("rsp", mon_act, mon_exp);
          end
        end
      end
    join_none

    // Reset values
    repeat (3) tick();
    check("rst_ready_valids", {req_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid,
                               m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    check("rst_addrs", {m_axi_awaddr, m_axi_araddr}, 0);
    check("rst_wdata", {m_axi_wdata, m_axi_wstrb}, 0);
    check("rst_rsp_fields", {rsp_write, rsp_timeout, rsp_resp, rsp_rdata}, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    #1;
    check("idle_req_ready", req_ready, 1);

    // Zero-wait write
    send(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 1'b1, pack(1'b1, 1'b0, 2'b00, 32'h0));
    check("wr_c1_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    check("wr_c1_awaddr", m_axi_awaddr, 32'h4);
    check("wr_c1_wdata", {m_axi_wdata, m_axi_wstrb}, {32'hDEADBEEF, 4'hF});
    tick();
    check("wr_c2_bready", {m_axi_bready, m_axi_awvalid, m_axi_wvalid}, 3'b100);
    tick();
    check("wr_c3_rsp_valid", rsp_valid, 1);
    wait_rsp("wr_zero_wait");

    // W completes 3 cycles before AW
    aw_delay = 3;
    cnt = b_count;
    send(1'b1, 32'h10, 32'hA5A50001, 4'h3, 1'b1, pack(1'b1, 1'b0, 2'b00, 32'h0));
    check("split_c1", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    tick();
    check("split_c2", {m_axi_awvalid, m_axi_wvalid}, 2'b10);
    tick();
    check("split_c3", {m_axi_awvalid, m_axi_wvalid}, 2'b10);
    tick();
    check("split_c4", {m_axi_awvalid, m_axi_wvalid, m_axi_wstrb}, {2'b10, 4'h3});
    tick();
    check("split_c5", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b001);
    wait_rsp("wr_split");
    check("split_b_count", b_count - cnt, 1);
    aw_delay = 0;

    // Read with 2 wait cycles on R
    r_delay = 2; r_data_cfg = 32'h12345678;
    send(1'b0, 32'h8, 32'h0, 4'h0, 1'b1, pack(1'b0, 1'b0, 2'b00, 32'h12345678));
    check("rd_c1", {m_axi_arvalid, m_axi_araddr}, {1'b1, 32'h8});
    wait_rsp("rd_wait");
    r_delay = 0;

    // Error codes pass through without timeout flag
    b_resp_cfg = 2'b10;
    send(1'b1, 32'h14, 32'h5, 4'h1, 1'b1, pack(1'b1, 1'b0, 2'b10, 32'h0));
    wait_rsp("wr_slverr");
    b_resp_cfg = 2'b00;
    r_resp_cfg = 2'b11; r_data_cfg = 32'h0F0F0F0F;
    send(1'b0, 32'h18, 32'h0, 4'h0, 1'b1, pack(1'b0, 1'b0, 2'b11, 32'h0F0F0F0F));
    wait_rsp("rd_decerr");
    r_resp_cfg = 2'b01; r_data_cfg = 32'h00000077;
    send(1'b0, 32'h1C, 32'h0, 4'h0, 1'b1, pack(1'b0, 1'b0, 2'b01, 32'h00000077));
    wait_rsp("rd_exokay");
    r_resp_cfg = 2'b00;

    // Read timeout with arready stuck low
    ar_delay = 1000;
    send(1'b0, 32'hC, 32'h0, 4'h0, 1'b1, pack(1'b0, 1'b1, 2'b10, 32'h0));
    cnt = 0;
    while (m_axi_arvalid && cnt < 40) begin
      cnt++;
      tick();
    end
    check("to_arvalid_cycles", cnt, 16);
    check("to_rsp_valid", rsp_valid, 1);
    tick();
    tick();
    ar_delay = 0;

    // Response back-pressure with a queued command waiting
    rsp_ready = 1'b0; r_data_cfg = 32'hCAFE0005;
    send(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, pack(1'b0, 1'b0, 2'b00, 32'hCAFE0005));
    req_write = 1'b1; req_addr = 32'h24; req_wdata = 32'h11; req_wstrb = 4'hF;
    req_valid = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_fields", {rsp_write, rsp_timeout, rsp_resp, rsp_rdata},
            pack(1'b0, 1'b0, 2'b00, 32'hCAFE0005));
      check("hold_req_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("hs_cycle_req_ready", req_ready, 0);
    exp_q.push_back(pack(1'b1, 1'b0, 2'b00, 32'h0));
    tick();
    check("post_hs_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    wait_rsp("queued_write");

    // Write timeout on a missing B response
    b_delay = 1000;
    send(1'b1, 32'h40, 32'h1, 4'hF, 1'b1, pack(1'b1, 1'b1, 2'b10, 32'h0));
    wait_rsp("wr_timeout");

    // Reset in WR_RESP: no response, then a clean write
    send(1'b1, 32'h30, 32'h99, 4'hF, 1'b0, '0);
    tick();
    check("rst_mid_state", dbg_state, WR_RESP);
    rst = 1'b1;
    tick();
    check("rst_mid_outputs", {req_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid,
                              m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    check("rst_mid_data", {m_axi_awaddr, m_axi_wdata}, 0);
    check("rst_mid_rsp", {rsp_write, rsp_timeout, rsp_resp, rsp_rdata}, 0);
    check("rst_mid_state_idle", dbg_state, IDLE);
    rst = 1'b0;
    b_delay = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_rsp", rsp_valid, 0);
    end
    send(1'b1, 32'h34, 32'h0BADF00D, 4'hF, 1'b1, pack(1'b1, 1'b0, 2'b00, 32'h0));
    check("post_rst_wdata", {m_axi_awaddr, m_axi_wdata}, {32'h34, 32'h0BADF00D});
    wait_rsp("post_rst_write");

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
